vec_result_collector: RTL
=========================

Name: vec_result_collector

Overview:
- Receiving end of the vector ALU lane interface.
- Each cycle it captures the per-lane result chunks (data, bit index, lane-valid) and assembles them into a VLEN-wide destination vector.
- On ALU completion it presents the assembled vector to the vector register file through a valid/ready writeback handshake.
- Sits between the lane wrapper and the vector register file write port.

Parameters:
- VLEN, 128, vector register width in bits (power of two, 64..512).
- LANE_WIDTH, 4, log2 of the maximum bits one lane writes per cycle (chunk = min(8<<vsew, 1<<LANE_WIDTH)).
- NB_LANES, 2, log2 of the lane count; supported range 0..3.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  begin a new collection; clears the buffer.
- vd_addr  in  5  destination register address, latched on accepted start.
- vsew  in  3  element width code (8<<vsew bits), latched on accepted start.
- lane_res  in  (1<<NB_LANES)  per-lane chunk-valid.
- lane_vd  in  (64<<NB_LANES)  per-lane result; lane i occupies bits [64i+63:64i], chunk in the low bits.
- lane_regi  in  (10<<NB_LANES)  per-lane destination bit index; lane i occupies bits [10i+9:10i].
- alu_done  in  1  final lane cycle indicator.
- wb_valid  out  1  writeback request.
- wb_ready  in  1  register file accepts writeback.
- wb_data  out  VLEN  assembled vector.
- wb_addr  out  5  latched vd_addr.
- wb_complete  out  1  every byte of wb_data was written during the collection.
- busy  out  1  state != IDLE.
- err_oob  out  1  sticky per collection: a chunk was out of range.

Behaviour:
- Reset (async, resetn low) forces:
  - state = IDLE.
  - wb_valid, busy, err_oob, wb_complete = 0.
  - wb_data = 0, wb_addr = 0.
  - byte-written mask = 0.
- chunk width cw = min(8<<vsew_q, 1<<LANE_WIDTH).
- vsew_q > 3 is illegal: treat it as cw = 1<<LANE_WIDTH and set err_oob.
- IDLE:
  - start=1 -> COLLECT next cycle; latch vd_addr and vsew.
  - Clear the buffer, mask and err_oob.
  - lane_res is ignored while in IDLE.
- COLLECT: every cycle, for each lane i with lane_res[i]=1:
  - If regi_i + cw <= VLEN: write buffer[regi_i +: cw] = lane_vd_i[cw-1:0] and set mask bits for bytes regi_i/8 .. (regi_i+cw)/8 - 1.
  - Otherwise drop the chunk and set err_oob.
  - All lanes write in the same cycle. Overlapping indices across lanes: the highest lane number wins.
  - A repeat write to the same bits overwrites the earlier value.
  - alu_done=1: that cycle's lane writes are still captured; the next state is WB.
- WB:
  - wb_valid=1.
  - wb_data = buffer; wb_addr = latched address.
  - wb_complete = (mask all ones).
  - The buffer is frozen; lane_res and alu_done are ignored.
  - wb_valid && wb_ready -> IDLE next cycle and wb_valid deasserts.
  - wb_valid holds until accepted; wb_data and wb_addr stay stable while waiting.
- start while busy is ignored. start in the same cycle as the WB handshake is also ignored; it must be reissued from IDLE.
- Latency: first lane write lands in the buffer 1 cycle after lane_res. wb_valid rises the cycle after alu_done.
- Minimum turnaround start -> wb_valid is 2 cycles when alu_done arrives in the first COLLECT cycle.
- Reset mid-operation aborts immediately; no writeback is issued.
- err_oob and wb_complete hold their values until the next accepted start.

Decomposition:
- Shared package vec_pkg:
  - state encoding: IDLE=2'b00, COLLECT=2'b01, WB=2'b10.
  - vsew codes E8..E64.
  - the chunk-width function.
  - lane slice width constants 64 and 10.
- One sub-module vec_lane_merge: a combinational merge of one lane chunk into a VLEN buffer plus byte mask, with an out-of-range flag.
  - Instantiate it via generate, (1<<NB_LANES) times, chained in lane order so the highest lane takes priority.

Test Plan:
- VLEN=128, NB_LANES=2, vsew=2 (32-bit, cw=16):
  - Stimulus: 4 lanes × 2 cycles, regi = 0,32,64,96 then 16,48,80,112, with data 0xAAAA.. patterns; alu_done on the second cycle.
  - Response: wb_data fully assembled, wb_complete=1, wb_valid exactly 1 cycle after alu_done.
- vsew=0 (cw=8):
  - Stimulus: 4 lanes, 4 cycles, regi covering only bytes 0..11; alu_done.
  - Response: wb_complete=0, bytes 12..15 = 0.
- Hold test:
  - Stimulus: wb_ready held low 5 cycles after wb_valid; toggle lane_res, alu_done and start meanwhile.
  - Response: wb_data and wb_addr unchanged, state stays WB; after wb_ready=1 the block returns to IDLE 1 cycle later.
- Out-of-range write:
  - Stimulus: lane_regi=120 with cw=16 (VLEN=128).
  - Response: chunk dropped, err_oob=1, other lanes written normally.
- Overlap:
  - Stimulus: lanes 0 and 3 both regi=0 in the same cycle with data 0x1111 / 0x3333.
  - Response: buffer[15:0]=0x3333.
- Reset mid-operation:
  - Stimulus: resetn low during COLLECT (asynchronous, between clock edges).
  - Response: busy=0 immediately; wb_valid never asserted; the next start yields a cleared buffer.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector result collector.
package vec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    WB      = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    E8  = 3'd0,
    E16 = 3'd1,
    E32 = 3'd2,
    E64 = 3'd3
  } sew_e;

  localparam int LANE_VD_W   = 64;
  localparam int LANE_REGI_W = 10;

  // Bits one lane writes per cycle; illegal sew codes fall back to the lane maximum.
  function automatic logic [6:0] chunk_width(input logic [2:0] sew, input int unsigned lane_width);
    int unsigned cmax;
    int unsigned c;
    cmax = 32'd1 << lane_width;
    c    = (sew > E64) ? cmax : (32'd8 << sew);
    if (c > cmax) c = cmax;
    return 7'(c);
  endfunction

endpackage

// File: rtl/vec_lane_merge.sv
// Combinational merge of one lane chunk into the destination buffer and byte mask.
module vec_lane_merge
  import vec_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic                   en,
  input  logic [LANE_VD_W-1:0]   data,
  input  logic [LANE_REGI_W-1:0] regi,
  input  logic [6:0]             cw,
  input  logic [VLEN-1:0]        buf_in,
  input  logic [VLEN/8-1:0]      mask_in,
  output logic [VLEN-1:0]        buf_out,
  output logic [VLEN/8-1:0]      mask_out,
  output logic                   oob
);

  localparam int NBY = VLEN / 8;

  logic [11:0]          stop;
  logic                 in_range;
  logic                 wr;
  logic [63:0]          low_m;
  logic [VLEN-1:0]      bit_m;
  logic [VLEN-1:0]      bit_d;
  logic [NBY-1:0]       byte_m;

  assign stop     = 12'(regi) + 12'(cw);
  assign in_range = (stop <= 12'(VLEN));
  assign wr       = en & in_range;
  assign oob      = en & ~in_range;

  // Shifting all-ones by the full width yields zero, so cw=64 gives a full mask.
  assign low_m  = ~({64{1'b1}} << cw);
  assign bit_m  = VLEN'(low_m) << regi;
  assign bit_d  = VLEN'(data & low_m) << regi;
  assign byte_m = ~({NBY{1'b1}} << stop[11:3]) & ({NBY{1'b1}} << regi[9:3]);

  assign buf_out  = wr ? ((buf_in & ~bit_m) | bit_d) : buf_in;
  assign mask_out = wr ? (mask_in | byte_m) : mask_in;

endmodule

// File: rtl/vec_result_collector.sv
// Collects per-lane ALU result chunks into a VLEN vector and writes it back via valid/ready.
module vec_result_collector
  import vec_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int NB_LANES   = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [4:0]                   vd_addr,
  input  logic [2:0]                   vsew,
  input  logic [(1<<NB_LANES)-1:0]     lane_res,
  input  logic [(64<<NB_LANES)-1:0]    lane_vd,
  input  logic [(10<<NB_LANES)-1:0]    lane_regi,
  input  logic                         alu_done,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [VLEN-1:0]              wb_data,
  output logic [4:0]                   wb_addr,
  output logic                         wb_complete,
  output logic                         busy,
  output logic                         err_oob
);

  localparam int NL  = 1 << NB_LANES;
  localparam int NBY = VLEN / 8;

  state_e                  state, state_nxt;
  logic [VLEN-1:0]         buf_q;
  logic [NBY-1:0]          mask_q;
  logic [2:0]              sew_q;
  logic [4:0]              addr_q;
  logic                    err_q;
  logic                    cmp_q;
  logic [6:0]              cw;
  logic                    collect;
  logic                    accept;

  logic [NL:0][VLEN-1:0]   buf_c;
  logic [NL:0][NBY-1:0]    msk_c;
  logic [NL-1:0]           oob_c;

  assign cw      = chunk_width(sew_q, LANE_WIDTH);
  assign collect = (state == COLLECT);
  assign accept  = (state == IDLE) && start;

  assign buf_c[0] = buf_q;
  assign msk_c[0] = mask_q;

  // Lanes chain in ascending order so the highest lane overwrites overlaps.
  for (genvar i = 0; i < NL; i++) begin : g_lane
    vec_lane_merge #(.VLEN(VLEN)) u_merge (
      .en       (collect & lane_res[i]),
      .data     (lane_vd[i*LANE_VD_W +: LANE_VD_W]),
      .regi     (lane_regi[i*LANE_REGI_W +: LANE_REGI_W]),
      .cw       (cw),
      .buf_in   (buf_c[i]),
      .mask_in  (msk_c[i]),
      .buf_out  (buf_c[i+1]),
      .mask_out (msk_c[i+1]),
      .oob      (oob_c[i])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = COLLECT;
      COLLECT: if (alu_done) state_nxt = WB;
      WB:      if (wb_ready) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_valid = (state == WB);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_q  <= '0;
      mask_q <= '0;
      sew_q  <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
      cmp_q  <= 1'b0;
    end else if (accept) begin
      buf_q  <= '0;
      mask_q <= '0;
      sew_q  <= vsew;
      addr_q <= vd_addr;
      err_q  <= (vsew > E64);
      cmp_q  <= 1'b0;
    end else if (collect) begin
      buf_q  <= buf_c[NL];
      mask_q <= msk_c[NL];
      err_q  <= err_q | (|oob_c);
      if (alu_done) cmp_q <= &msk_c[NL];
    end
  end

  assign wb_data     = buf_q;
  assign wb_addr     = addr_q;
  assign wb_complete = cmp_q;
  assign err_oob     = err_q;

endmodule
